// File: rtl/median3x3_col_stream.sv
// -----------------------------------------------------------------------------
// median3x3_col_stream
//   Streaming 3x3 median stage feeding the Gaussian filter. It accepts one
//   vertical 3-pixel column per cycle along a horizontal strip. It keeps a
//   sliding 3-column window of pre-sorted columns. Once the window is full it
//   emits one median per accepted column. The median is found with the
//   classic lo-max / mid-med / hi-min reduction over two pipeline stages.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       synchronous strip start: clears counter, window, pipeline
//   col_valid   column on pix_* is valid this cycle
//   pix_top/mid/bot  window column pixels (BIT_LENGTH bits, unsigned)
//   col_ready   high while the strip still has room for another column
//   med_valid   med_out / med_col valid this cycle
//   med_out     median of the 9 window pixels
//   med_col     image column of the window centre (1..IMG_DIM-2)
//   strip_done  pulse coincident with the last median of the strip
//   med_count   (only with MED_STATS_EN) saturating count of medians since
//               the last start or reset
//
// Build option
//   `define MED_STATS_EN  adds the med_count output and its counter.
// -----------------------------------------------------------------------------
module median3x3_col_stream #(
    parameter int BIT_LENGTH = 5,
    parameter int IMG_DIM    = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  col_valid,
    input  logic [BIT_LENGTH-1:0] pix_top,
    input  logic [BIT_LENGTH-1:0] pix_mid,
    input  logic [BIT_LENGTH-1:0] pix_bot,
    output logic                  col_ready,
    output logic                  med_valid,
    output logic [BIT_LENGTH-1:0] med_out,
    output logic [4:0]            med_col,
    output logic                  strip_done
`ifdef MED_STATS_EN
    ,
    output logic [8:0]            med_count
`endif
);

    localparam int               CNT_W    = $clog2(IMG_DIM + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMG_DIM);
    localparam logic [4:0]       LAST_COL = 5'(IMG_DIM - 2);

    typedef logic [BIT_LENGTH-1:0] pix_t;
    typedef struct packed {
        pix_t hi;
        pix_t mid;
        pix_t lo;
    } scol_t;

    localparam scol_t SCOL_ZERO = {(3 * BIT_LENGTH){1'b0}};

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Three compare-exchange stages: (a,b), then (hi(a,b),c), then the two lows.
    function automatic scol_t sort3(input pix_t a, input pix_t b, input pix_t c);
        scol_t res;
        pix_t  l01;
        pix_t  h01;
        pix_t  tmp;
        l01     = min2(a, b);
        h01     = max2(a, b);
        res.hi  = max2(h01, c);
        tmp     = min2(h01, c);
        res.lo  = min2(l01, tmp);
        res.mid = max2(l01, tmp);
        return res;
    endfunction

    // Stage 0: counter and window of sorted columns (w0 newest).
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt_s;
    logic             accept_s;
    scol_t            new_col_s;
    scol_t            w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic             v0_q, v0_d;
    logic [4:0]       col0_q, col0_d;
    // Stage 1: lo-max / mid-med / hi-min of the window.
    logic             v1_q, v1_d;
    pix_t             lo_max_q, lo_max_d, mid_med_q, mid_med_d, hi_min_q, hi_min_d;
    logic [4:0]       col1_q, col1_d;
    // Stage 2: registered outputs.
    logic             med_valid_q, med_valid_d;
    pix_t             med_out_q, med_out_d;
    logic [4:0]       med_col_q, med_col_d;
    logic             strip_done_q, strip_done_d;

    // Next-state for the counter, window and both pipeline stages.
    always_comb begin
        // start clears first, so a simultaneous column lands as column 0.
        base_cnt_s = start ? {CNT_W{1'b0}} : cnt_q;
        accept_s   = col_valid & (start | (cnt_q < CNT_FULL));
        new_col_s  = sort3(pix_top, pix_mid, pix_bot);

        if (start) begin
            w0_d = SCOL_ZERO;
            w1_d = SCOL_ZERO;
            w2_d = SCOL_ZERO;
        end else begin
            w0_d = w0_q;
            w1_d = w1_q;
            w2_d = w2_q;
        end

        if (accept_s) begin
            cnt_d  = base_cnt_s + CNT_W'(1);
            w2_d   = start ? SCOL_ZERO : w1_q;
            w1_d   = start ? SCOL_ZERO : w0_q;
            w0_d   = new_col_s;
            v0_d   = (base_cnt_s >= CNT_W'(2));
            col0_d = 5'(base_cnt_s - CNT_W'(1));
        end else begin
            cnt_d  = base_cnt_s;
            v0_d   = 1'b0;
            col0_d = col0_q;
        end

        // The window registered at the previous edge is reduced here.
        v1_d = v0_q & ~start;
        if (v0_q) begin
            lo_max_d  = max3(w0_q.lo, w1_q.lo, w2_q.lo);
            mid_med_d = med3(w0_q.mid, w1_q.mid, w2_q.mid);
            hi_min_d  = min3(w0_q.hi, w1_q.hi, w2_q.hi);
            col1_d    = col0_q;
        end else begin
            lo_max_d  = lo_max_q;
            mid_med_d = mid_med_q;
            hi_min_d  = hi_min_q;
            col1_d    = col1_q;
        end

        med_valid_d  = v1_q & ~start;
        strip_done_d = v1_q & ~start & (col1_q == LAST_COL);
        if (v1_q) begin
            med_out_d = med3(lo_max_q, mid_med_q, hi_min_q);
            med_col_d = col1_q;
        end else begin
            med_out_d = med_out_q;
            med_col_d = med_col_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= {CNT_W{1'b0}};
            w0_q         <= SCOL_ZERO;
            w1_q         <= SCOL_ZERO;
            w2_q         <= SCOL_ZERO;
            v0_q         <= 1'b0;
            col0_q       <= 5'd0;
            v1_q         <= 1'b0;
            lo_max_q     <= {BIT_LENGTH{1'b0}};
            mid_med_q    <= {BIT_LENGTH{1'b0}};
            hi_min_q     <= {BIT_LENGTH{1'b0}};
            col1_q       <= 5'd0;
            med_valid_q  <= 1'b0;
            med_out_q    <= {BIT_LENGTH{1'b0}};
            med_col_q    <= 5'd0;
            strip_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            w0_q         <= w0_d;
            w1_q         <= w1_d;
            w2_q         <= w2_d;
            v0_q         <= v0_d;
            col0_q       <= col0_d;
            v1_q         <= v1_d;
            lo_max_q     <= lo_max_d;
            mid_med_q    <= mid_med_d;
            hi_min_q     <= hi_min_d;
            col1_q       <= col1_d;
            med_valid_q  <= med_valid_d;
            med_out_q    <= med_out_d;
            med_col_q    <= med_col_d;
            strip_done_q <= strip_done_d;
        end
    end

    assign col_ready  = (cnt_q < CNT_FULL);
    assign med_valid  = med_valid_q;
    assign med_out    = med_out_q;
    assign med_col    = med_col_q;
    assign strip_done = strip_done_q;

`ifdef MED_STATS_EN
    logic [8:0] med_count_q, med_count_d;

    // Median counter: start wins over a same-cycle median, saturates at 511.
    always_comb begin
        if (start) begin
            med_count_d = 9'd0;
        end else if (med_valid_q && (med_count_q != 9'd511)) begin
            med_count_d = med_count_q + 9'd1;
        end else begin
            med_count_d = med_count_q;
        end
    end

    // Median counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            med_count_q <= 9'd0;
        end else begin
            med_count_q <= med_count_d;
        end
    end

    assign med_count = med_count_q;
`endif

endmodule

// File: tb/tb_median3x3_col_stream.sv
// -----------------------------------------------------------------------------
// Directed bench for median3x3_col_stream. Inputs change and outputs are
// sampled 1 ns after each rising edge. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_median3x3_col_stream;

    localparam int BL = 5;

    logic          clk;
    logic          reset;
    logic          start;
    logic          col_valid;
    logic [BL-1:0] pix_top;
    logic [BL-1:0] pix_mid;
    logic [BL-1:0] pix_bot;
    logic          col_ready;
    logic          med_valid;
    logic [BL-1:0] med_out;
    logic [4:0]    med_col;
    logic          strip_done;
`ifdef MED_STATS_EN
    logic [8:0]    med_count;
`endif

    int checks_cnt = 0;
    int fail_cnt   = 0;

    median3x3_col_stream #(
        .BIT_LENGTH (BL),
        .IMG_DIM    (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .col_valid  (col_valid),
        .pix_top    (pix_top),
        .pix_mid    (pix_mid),
        .pix_bot    (pix_bot),
        .col_ready  (col_ready),
        .med_valid  (med_valid),
        .med_out    (med_out),
        .med_col    (med_col),
        .strip_done (strip_done)
`ifdef MED_STATS_EN
        ,
        .med_count  (med_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v,
                         input logic [BL-1:0] t, input logic [BL-1:0] m, input logic [BL-1:0] b);
        start     = s;
        col_valid = v;
        pix_top   = t;
        pix_mid   = m;
        pix_bot   = b;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #12;
        check_val("rst_med_valid", med_valid, 1'b0);
        check_val("rst_col_ready", col_ready, 1'b1);
        check_val("rst_med_out", med_out, 5'd0);
        check_val("rst_med_col", med_col, 5'd0);
        check_val("rst_strip_done", strip_done, 1'b0);
`ifdef MED_STATS_EN
        check_val("rst_med_count", med_count, 9'd0);
`endif
        reset = 1'b0;

        // Basic window: median of 1..9 is 5 at centre column 1.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        drive(1'b0, 1'b1, 5'd1, 5'd2, 5'd3); tick();
        check_val("basic_v_e0", med_valid, 1'b0);
        drive(1'b0, 1'b1, 5'd4, 5'd5, 5'd6); tick();
        check_val("basic_v_e1", med_valid, 1'b0);
        drive(1'b0, 1'b1, 5'd7, 5'd8, 5'd9); tick();
        check_val("basic_v_e2", med_valid, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        check_val("basic_v_e3", med_valid, 1'b0);
        tick();
        check_val("basic_v_e4", med_valid, 1'b1);
        check_val("basic_med", med_out, 5'd5);
        check_val("basic_col", med_col, 5'd1);
        tick();
        check_val("basic_v_e5", med_valid, 1'b0);

        // Reset mid-strip with cnt=7 and medians in flight.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd9); tick();
        end
        check_val("prerst_valid", med_valid, 1'b1);
        check_val("prerst_med", med_out, 5'd9);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #3 reset = 1'b1;
        #1;
        check_val("midrst_valid", med_valid, 1'b0);
        check_val("midrst_ready", col_ready, 1'b1);
        check_val("midrst_med", med_out, 5'd0);
        check_val("midrst_col", med_col, 5'd0);
        #2 reset = 1'b0;
        // Pixels {31,0,15,2,2,2,10,20,5}: sorted 5th value is 5.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        drive(1'b0, 1'b1, 5'd31, 5'd0, 5'd15); tick();
        drive(1'b0, 1'b1, 5'd2, 5'd2, 5'd2); tick();
        drive(1'b0, 1'b1, 5'd10, 5'd20, 5'd5); tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        check_val("postrst_v_early", med_valid, 1'b0);
        tick();
        check_val("postrst_valid", med_valid, 1'b1);
        check_val("postrst_med", med_out, 5'd5);
        check_val("postrst_col", med_col, 5'd1);

        // Impulse strip, then ignored 21st+ columns of 31s.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        check_val("imp_start_valid", med_valid, 1'b0);
        for (int i = 0; i < 24; i++) begin
            if (i < 20) drive(1'b0, 1'b1, 5'd0, (i == 5) ? 5'd31 : 5'd0, 5'd0);
            else        drive(1'b0, 1'b1, 5'd31, 5'd31, 5'd31);
            tick();
            check_val($sformatf("imp_ready[%0d]", i), col_ready, (i < 19));
            check_val($sformatf("imp_valid[%0d]", i), med_valid, (i >= 4 && i <= 21));
            check_val($sformatf("imp_done[%0d]", i), strip_done, (i == 21));
            if (i >= 4 && i <= 21) begin
                check_val($sformatf("imp_med[%0d]", i), med_out, 5'd0);
                check_val($sformatf("imp_col[%0d]", i), med_col, i - 3);
            end
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
`ifdef MED_STATS_EN
        check_val("stats_full", med_count, 9'd18);
`endif

        // Gaps: constant 17, col_valid toggling; last median left in flight.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        check_val("gap_start_valid", med_valid, 1'b0);
`ifdef MED_STATS_EN
        check_val("stats_cleared", med_count, 9'd0);
`endif
        for (int j = 0; j < 10; j++) begin
            drive(1'b0, (j % 2 == 0), 5'd17, 5'd17, 5'd17); tick();
            check_val($sformatf("gap_valid[%0d]", j), med_valid, (j == 6 || j == 8));
            check_val($sformatf("gap_ready[%0d]", j), col_ready, 1'b1);
            if (j == 6 || j == 8) begin
                check_val($sformatf("gap_med[%0d]", j), med_out, 5'd17);
                check_val($sformatf("gap_col[%0d]", j), med_col, (j - 2) / 2 - 1);
            end
        end

        // start && col_valid: flush in-flight median, column becomes column 0.
        drive(1'b1, 1'b1, 5'd1, 5'd1, 5'd1); tick();
        check_val("rs_flush", med_valid, 1'b0);
        drive(1'b0, 1'b1, 5'd2, 5'd2, 5'd2); tick();
        check_val("rs_v1", med_valid, 1'b0);
        drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd3); tick();
        check_val("rs_v2", med_valid, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        check_val("rs_v3", med_valid, 1'b0);
        tick();
        check_val("rs_valid", med_valid, 1'b1);
        check_val("rs_med", med_out, 5'd2);
        check_val("rs_col", med_col, 5'd1);
        tick();
        check_val("rs_v5", med_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
